// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the in-order core datapath and its pipeline sequencer.
// The datapath side is the master; pipe_ctrl is the slave.
interface pipe_ctrl_if #(
  parameter int STAGES  = 5,
  parameter int RADDR_W = 5,
  parameter int FSEL_W  = $clog2(STAGES)
);
  logic [RADDR_W-1:0] id_rs;
  logic [RADDR_W-1:0] id_rt;
  logic [RADDR_W-1:0] id_rd;
  logic               id_use_rs;
  logic               id_use_rt;
  logic               id_regwrite;
  logic               id_load;
  logic               ex_branch_taken;
  logic               mem_req;
  logic               mem_ack;
  logic [STAGES-1:0]  stage_en;
  logic [STAGES-1:0]  stage_valid;
  logic               pc_en;
  logic               pc_sel;
  logic               ex_bubble;
  logic [FSEL_W-1:0]  fwd_a;
  logic [FSEL_W-1:0]  fwd_b;
  logic [15:0]        stall_cycles;
  logic [15:0]        flush_count;

  modport master (
    output id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_regwrite, id_load,
           ex_branch_taken, mem_req, mem_ack,
    input  stage_en, stage_valid, pc_en, pc_sel, ex_bubble, fwd_a, fwd_b,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_regwrite, id_load,
           ex_branch_taken, mem_req, mem_ack,
    output stage_en, stage_valid, pc_en, pc_sel, ex_bubble, fwd_a, fwd_b,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables, load-use bubbles, memory waits, branch flush, forwarding.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
//
// state   | meaning
// RUN     | normal advance (flush allowed)
// LDSTALL | one-cycle load-use bubble just inserted into EX
// MEMWAIT | pipeline frozen waiting for data-memory ack
module pipe_ctrl #(
  parameter int STAGES  = 5,
  parameter int RADDR_W = 5,
  parameter int FSEL_W  = $clog2(STAGES)
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] LDSTALL = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;

  logic [1:0]         state_q;
  logic [1:0]         state_nxt;
  logic [STAGES-1:0]  valid_q;
  logic [RADDR_W-1:0] rd_q [2:STAGES-1];
  logic [STAGES-1:2]  wr_q;
  logic               ex_load_q;
  logic [RADDR_W-1:0] ex_rs_q;
  logic [RADDR_W-1:0] ex_rt_q;

  logic               mem_stall;
  logic               flush;
  logic               ex_hazard;
  logic               ld_stall;
  logic               ex_in_valid;
  logic [STAGES-1:0]  en;

  assign mem_stall = valid_q[3] && bus.mem_req && !bus.mem_ack;
  assign flush     = bus.ex_branch_taken && !mem_stall;
  assign ex_hazard = valid_q[2] && ex_load_q && wr_q[2] && (rd_q[2] != '0) &&
                     ((bus.id_use_rs && (bus.id_rs == rd_q[2])) ||
                      (bus.id_use_rt && (bus.id_rt == rd_q[2])));
  // EX always holds a bubble while in LDSTALL, so a second stall cannot follow
  assign ld_stall    = ex_hazard && !mem_stall && !flush && (state_q != LDSTALL);
  assign ex_in_valid = valid_q[1] && !flush && !ld_stall;

  always_comb begin
    en            = '0;
    bus.pc_en     = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.ex_bubble = 1'b0;
    state_nxt     = RUN;
    if (mem_stall)     state_nxt = MEMWAIT;
    else if (ld_stall) state_nxt = LDSTALL;
    if (rst_n && !mem_stall) begin
      en            = '1;
      bus.pc_en     = !ld_stall;
      bus.pc_sel    = flush;
      bus.ex_bubble = ld_stall;
      if (ld_stall) en[1:0] = 2'b00;
    end
  end

  assign bus.stage_en    = en;
  assign bus.stage_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      valid_q   <= '0;
      wr_q      <= '0;
      ex_load_q <= 1'b0;
      ex_rs_q   <= '0;
      ex_rt_q   <= '0;
      for (int k = 2; k < STAGES; k++) rd_q[k] <= '0;
    end else begin
      state_q <= state_nxt;
      if (en[0]) valid_q[0] <= 1'b1;
      if (en[1]) valid_q[1] <= valid_q[0] && !flush;
      if (en[2]) begin
        valid_q[2] <= ex_in_valid;
        rd_q[2]    <= ex_in_valid ? bus.id_rd : '0;
        wr_q[2]    <= ex_in_valid && bus.id_regwrite;
        ex_load_q  <= ex_in_valid && bus.id_load;
        ex_rs_q    <= ex_in_valid ? bus.id_rs : '0;
        ex_rt_q    <= ex_in_valid ? bus.id_rt : '0;
      end
      for (int k = 3; k < STAGES; k++) begin
        if (en[k]) begin
          valid_q[k] <= valid_q[k-1];
          rd_q[k]    <= rd_q[k-1];
          wr_q[k]    <= wr_q[k-1];
        end
      end
    end
  end

  // Scan oldest to youngest so the youngest matching producer overrides
  always_comb begin
    bus.fwd_a = '0;
    bus.fwd_b = '0;
    for (int k = STAGES-1; k >= 3; k--) begin
      if (valid_q[k] && wr_q[k] && (rd_q[k] != '0)) begin
        if (rd_q[k] == ex_rs_q) bus.fwd_a = FSEL_W'(k);
        if (rd_q[k] == ex_rt_q) bus.fwd_b = FSEL_W'(k);
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((state_nxt != RUN) && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush && (flush_q != 16'hFFFF))             flush_q <= flush_q + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = 16'h0000;
  assign bus.flush_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus randomized traffic
// compared against a stage-array reference model.
module tb_pipe_ctrl;
  localparam int STAGES  = 5;
  localparam int RADDR_W = 5;
  localparam int FSEL_W  = $clog2(STAGES);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(STAGES), .RADDR_W(RADDR_W), .FSEL_W(FSEL_W)) bus ();

  pipe_ctrl #(.STAGES(STAGES), .RADDR_W(RADDR_W), .FSEL_W(FSEL_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic               v;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic               wr;
    logic               ld;
  } ent_t;

  ent_t m [STAGES];
  int   m_stall, m_flush;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [STAGES-1:0] e_en, e_valid;
  logic              e_pc_en, e_pc_sel, e_bub, e_mw, e_fl, e_hz;
  logic [FSEL_W-1:0] e_fa, e_fb;

  function automatic logic [15:0] perf(input int v);
`ifdef PIPE_CTRL_PERF_EN
    return (v > 65535) ? 16'hFFFF : 16'(v);
`else
    return 16'h0000 & 16'(v);
`endif
  endfunction

  // Youngest (lowest-numbered) stage from MEM onward that writes src wins.
  function automatic logic [FSEL_W-1:0] fwd_src(input logic [RADDR_W-1:0] src);
    for (int k = 3; k < STAGES; k++)
      if (m[k].v && m[k].wr && m[k].rd != 0 && m[k].rd == src) return FSEL_W'(k);
    return '0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) m[k] = '{default: '0};
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_comb();
    e_mw = m[3].v && bus.mem_req && !bus.mem_ack;
    e_fl = !e_mw && bus.ex_branch_taken;
    e_hz = !e_mw && !e_fl && m[2].v && m[2].ld && m[2].wr && m[2].rd != 0 &&
           ((bus.id_use_rs && bus.id_rs == m[2].rd) || (bus.id_use_rt && bus.id_rt == m[2].rd));
    if (e_mw)      e_en = '0;
    else if (e_hz) e_en = {{(STAGES-2){1'b1}}, 2'b00};
    else           e_en = '1;
    e_pc_en  = !e_mw && !e_hz;
    e_pc_sel = e_fl;
    e_bub    = e_hz;
    e_fa     = fwd_src(m[2].rs);
    e_fb     = fwd_src(m[2].rt);
    for (int k = 0; k < STAGES; k++) e_valid[k] = m[k].v;
  endtask

  task automatic model_advance();
    model_comb();
    if (e_mw || e_hz) m_stall++;
    if (e_fl) m_flush++;
    if (e_mw) return;
    for (int k = STAGES-1; k >= 3; k--) m[k] = m[k-1];
    if (m[1].v && !e_fl && !e_hz)
      m[2] = '{v: 1'b1, rd: bus.id_rd, rs: bus.id_rs, rt: bus.id_rt,
               wr: bus.id_regwrite, ld: bus.id_load};
    else
      m[2] = '{default: '0};
    if (!e_hz) begin
      m[1].v = m[0].v && !e_fl;
      m[0].v = 1'b1;
    end
  endtask

  task automatic clear_in();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.id_regwrite = 1'b0; bus.id_load = 1'b0;
    bus.ex_branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill();
    repeat (STAGES) tick();
  endtask

  task automatic set_id(input int rd, input bit wr, input bit ld,
                        input int rs, input bit urs, input int rt, input bit urt);
    bus.id_rd = RADDR_W'(rd); bus.id_regwrite = wr; bus.id_load = ld;
    bus.id_rs = RADDR_W'(rs); bus.id_use_rs = urs;
    bus.id_rt = RADDR_W'(rt); bus.id_use_rt = urt;
  endtask

  task automatic issue(input int rd, input bit wr, input bit ld,
                       input int rs, input bit urs, input int rt, input bit urt);
    set_id(rd, wr, ld, rs, urs, rt, urt);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1; bus.id_regwrite = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.stage_en !== '0) begin n_err++; $display("FAIL rst_stage_en: got %b want 0", bus.stage_en); end
    n_cmp++; if (bus.pc_en !== 1'b0 || bus.pc_sel !== 1'b0 || bus.ex_bubble !== 1'b0) begin
      n_err++; $display("FAIL rst_pc_bub: got pc_en=%b pc_sel=%b bub=%b want 0", bus.pc_en, bus.pc_sel, bus.ex_bubble); end
    n_cmp++; if (bus.stage_valid !== '0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.stage_valid); end
    n_cmp++; if (bus.fwd_a !== '0 || bus.fwd_b !== '0) begin n_err++; $display("FAIL rst_fwd: got %0d/%0d want 0", bus.fwd_a, bus.fwd_b); end
    n_cmp++; if (bus.stall_cycles !== 16'h0 || bus.flush_count !== 16'h0) begin
      n_err++; $display("FAIL rst_counters: got %0d/%0d want 0", bus.stall_cycles, bus.flush_count); end
    clear_in();
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < STAGES; c++) begin
      #1;
      n_cmp++; if (bus.stage_valid !== STAGES'((1 << c) - 1)) begin
        n_err++; $display("FAIL fill_valid[%0d]: got %b want %b", c, bus.stage_valid, STAGES'((1 << c) - 1)); end
      n_cmp++; if (bus.stage_en !== '1 || bus.pc_en !== 1'b1) begin
        n_err++; $display("FAIL fill_en[%0d]: got en=%b pc_en=%b want all 1", c, bus.stage_en, bus.pc_en); end
      tick();
    end
    #1;
    n_cmp++; if (bus.stage_valid !== '1) begin n_err++; $display("FAIL fill_full: got %b want all 1", bus.stage_valid); end
  endtask

  task automatic test_forwarding();
    do_reset(); fill();
    issue(3, 1, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 3, 1, 0, 0);
    #1; n_cmp++; if (bus.fwd_a !== 3'd3) begin n_err++; $display("FAIL fwd_mem: got %0d want 3", bus.fwd_a); end
    issue(7, 1, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 7, 1, 0, 0);
    #1; n_cmp++; if (bus.fwd_a !== 3'd4) begin n_err++; $display("FAIL fwd_wb: got %0d want 4", bus.fwd_a); end
    issue(9, 1, 0, 0, 0, 0, 0);
    issue(9, 1, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 9, 1, 0, 0);
    #1; n_cmp++; if (bus.fwd_a !== 3'd3) begin n_err++; $display("FAIL fwd_youngest: got %0d want 3", bus.fwd_a); end
    issue(0, 1, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 1, 0, 0);
    #1; n_cmp++; if (bus.fwd_a !== 3'd0) begin n_err++; $display("FAIL fwd_r0: got %0d want 0", bus.fwd_a); end
    issue(11, 1, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 1, 1, 11, 1);
    #1; n_cmp++; if (bus.fwd_b !== 3'd3 || bus.fwd_a !== 3'd0) begin
      n_err++; $display("FAIL fwd_rt: got a=%0d b=%0d want a=0 b=3", bus.fwd_a, bus.fwd_b); end
    clear_in();
  endtask

  task automatic test_load_use();
    do_reset(); fill();
    issue(5, 1, 1, 0, 0, 0, 0);
    set_id(0, 0, 0, 5, 1, 0, 0);
    #1;
    n_cmp++; if (bus.pc_en !== 1'b0 || bus.ex_bubble !== 1'b1) begin
      n_err++; $display("FAIL ldu_stall: got pc_en=%b bub=%b want 0/1", bus.pc_en, bus.ex_bubble); end
    n_cmp++; if (bus.stage_en !== 5'b11100) begin n_err++; $display("FAIL ldu_en: got %b want 11100", bus.stage_en); end
    tick(); #1;
    n_cmp++; if (bus.stage_valid !== 5'b11011) begin n_err++; $display("FAIL ldu_valid: got %b want 11011", bus.stage_valid); end
    n_cmp++; if (bus.stall_cycles !== perf(1)) begin n_err++; $display("FAIL ldu_stall_cnt: got %0d want %0d", bus.stall_cycles, perf(1)); end
    n_cmp++; if (bus.pc_en !== 1'b1 || bus.ex_bubble !== 1'b0) begin
      n_err++; $display("FAIL ldu_resume: got pc_en=%b bub=%b want 1/0", bus.pc_en, bus.ex_bubble); end
    tick(); #1;
    n_cmp++; if (bus.fwd_a !== 3'd4) begin n_err++; $display("FAIL ldu_fwd: got %0d want 4", bus.fwd_a); end
    clear_in();
  endtask

  task automatic test_mem_wait();
    do_reset(); fill();
    bus.mem_req = 1'b1; bus.mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (bus.stage_en !== '0 || bus.pc_en !== 1'b0) begin
        n_err++; $display("FAIL mw_frozen[%0d]: got en=%b pc_en=%b want 0", c, bus.stage_en, bus.pc_en); end
      tick();
    end
    bus.mem_ack = 1'b1;
    #1;
    n_cmp++; if (bus.stage_en !== '1 || bus.pc_en !== 1'b1) begin
      n_err++; $display("FAIL mw_ack: got en=%b pc_en=%b want all 1", bus.stage_en, bus.pc_en); end
    tick(); #1;
    n_cmp++; if (bus.stall_cycles !== perf(3)) begin n_err++; $display("FAIL mw_cnt: got %0d want %0d", bus.stall_cycles, perf(3)); end
    bus.mem_req = 1'b0; bus.mem_ack = 1'b1;
    #1;
    n_cmp++; if (bus.stage_en !== '1) begin n_err++; $display("FAIL mw_ack_noreq: got %b want all 1", bus.stage_en); end
    clear_in();
  endtask

  task automatic test_branch_flush();
    do_reset(); fill();
    issue(5, 1, 1, 0, 0, 0, 0);
    set_id(0, 0, 0, 5, 1, 0, 0);
    bus.ex_branch_taken = 1'b1;
    #1;
    n_cmp++; if (bus.pc_sel !== 1'b1 || bus.pc_en !== 1'b1 || bus.ex_bubble !== 1'b0) begin
      n_err++; $display("FAIL br_ctl: got sel=%b pc_en=%b bub=%b want 1/1/0", bus.pc_sel, bus.pc_en, bus.ex_bubble); end
    n_cmp++; if (bus.stage_en !== '1) begin n_err++; $display("FAIL br_en: got %b want all 1", bus.stage_en); end
    tick(); #1;
    n_cmp++; if (bus.stage_valid !== 5'b11001) begin n_err++; $display("FAIL br_valid: got %b want 11001", bus.stage_valid); end
    n_cmp++; if (bus.flush_count !== perf(1)) begin n_err++; $display("FAIL br_cnt: got %0d want %0d", bus.flush_count, perf(1)); end
    bus.mem_req = 1'b1; bus.mem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (bus.pc_sel !== 1'b0 || bus.stage_en !== '0) begin
        n_err++; $display("FAIL br_mw[%0d]: got sel=%b en=%b want 0", c, bus.pc_sel, bus.stage_en); end
      tick();
    end
    bus.mem_ack = 1'b1;
    #1;
    n_cmp++; if (bus.pc_sel !== 1'b1 || bus.stage_en !== '1) begin
      n_err++; $display("FAIL br_mw_ack: got sel=%b en=%b want 1/all 1", bus.pc_sel, bus.stage_en); end
    tick(); #1;
    n_cmp++; if (bus.flush_count !== perf(2) || bus.stall_cycles !== perf(2)) begin
      n_err++; $display("FAIL br_mw_cnt: got flush=%0d stall=%0d want %0d/%0d", bus.flush_count, bus.stall_cycles, perf(2), perf(2)); end
    clear_in();
  endtask

  task automatic test_reset_midwait();
    do_reset(); fill();
    bus.mem_req = 1'b1; bus.mem_ack = 1'b0; bus.ex_branch_taken = 1'b1;
    tick(); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (bus.stage_en !== '0 || bus.pc_en !== 1'b0 || bus.pc_sel !== 1'b0 || bus.ex_bubble !== 1'b0) begin
      n_err++; $display("FAIL rmw_ctl: got en=%b pc_en=%b sel=%b bub=%b want 0", bus.stage_en, bus.pc_en, bus.pc_sel, bus.ex_bubble); end
    n_cmp++; if (bus.stage_valid !== '0 || bus.stall_cycles !== 16'h0) begin
      n_err++; $display("FAIL rmw_state: got valid=%b stall=%0d want 0", bus.stage_valid, bus.stall_cycles); end
    bus.ex_branch_taken = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.pc_en !== 1'b1 || bus.stage_en !== '1) begin
      n_err++; $display("FAIL rmw_restart: got pc_en=%b en=%b want 1/all 1", bus.pc_en, bus.stage_en); end
    tick(); #1;
    n_cmp++; if (bus.stage_valid !== 5'b00001) begin n_err++; $display("FAIL rmw_valid: got %b want 00001", bus.stage_valid); end
    clear_in();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_id($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
      bus.ex_branch_taken = ($urandom_range(0, 9) == 0);
      bus.mem_req = ($urandom_range(0, 2) == 0);
      bus.mem_ack = $urandom_range(0, 1);
      #1;
      model_comb();
      n_cmp++; if (bus.stage_en !== e_en || bus.pc_en !== e_pc_en || bus.pc_sel !== e_pc_sel || bus.ex_bubble !== e_bub) begin
        n_err++; $display("FAIL rnd_ctl[%0d]: got en=%b pc=%b sel=%b bub=%b want en=%b pc=%b sel=%b bub=%b",
                          c, bus.stage_en, bus.pc_en, bus.pc_sel, bus.ex_bubble, e_en, e_pc_en, e_pc_sel, e_bub); end
      n_cmp++; if (bus.fwd_a !== e_fa || bus.fwd_b !== e_fb) begin
        n_err++; $display("FAIL rnd_fwd[%0d]: got %0d/%0d want %0d/%0d", c, bus.fwd_a, bus.fwd_b, e_fa, e_fb); end
      n_cmp++; if (bus.stage_valid !== e_valid) begin
        n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.stage_valid, e_valid); end
      n_cmp++; if (bus.stall_cycles !== perf(m_stall) || bus.flush_count !== perf(m_flush)) begin
        n_err++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", c, bus.stall_cycles, bus.flush_count, perf(m_stall), perf(m_flush)); end
      tick();
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    model_reset();
    test_reset();
    test_fill();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_branch_flush();
    test_reset_midwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline sequencer for the in-order RISC core: generates per-stage register enables, PC enable, bubble insertion, branch flush and operand forwarding selects for a pipeline of configurable depth. Replaces the fixed four-enable scheme between the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It adds load-use hazard stalls, variable-latency data-memory waits and taken-branch flushes. The block tracks per-stage valid/destination state internally. The datapath only supplies decoded fields and status.

## Interface
- STAGES, 5, pipeline depth (IF=0, ID=1, EX=2, MEM=3, 4..STAGES-1 writeback tail); legal 5..8
- RADDR_W, 5, register address width
- FSEL_W, $clog2(STAGES), forwarding-select width

- clk  in  1  core clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  RADDR_W  source registers of instruction in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- id_rd  in  RADDR_W  destination of ID instruction
- id_regwrite  in  1  ID instruction writes a register
- id_load  in  1  ID instruction is a load (MemRD)
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- mem_req  in  1  MEM stage issues a data-memory access
- mem_ack  in  1  data memory completes access this cycle
- stage_en  out  STAGES  enable for register feeding stage k (bit 0 = PC/IF)
- stage_valid  out  STAGES  stage k holds a real instruction
- pc_en  out  1  PC register update enable
- pc_sel  out  1  1 = PC loads branch target
- ex_bubble  out  1  ID/EX register loads a NOP this cycle
- fwd_a, fwd_b  out  FSEL_W  EX operand source: 0 = regfile, k = stage k result
- stall_cycles  out  16  saturating stall counter
- flush_count  out  16  saturating flush counter

## Operation
- Internal per stage k>=2: valid, rd, regwrite, load, plus EX-held rs/rt; these shift on stage_en.
- FSM states: RUN, LDSTALL, MEMWAIT.
- Priority, highest first: memory wait, branch flush, load-use stall, normal advance.
- MEMWAIT: entered when stage_valid[3] && mem_req && !mem_ack. All stage_en=0, pc_en=0, no state change. Exit to RUN on the cycle mem_ack=1; that cycle advances normally.
- Flush: ex_branch_taken in RUN. pc_sel=1, pc_en=1, all stage_en=1. Valid of IF and ID entries entering ID and EX cleared. Load-use stall suppressed that cycle. flush_count +1.
- Load-use: EX valid && EX load && EX regwrite && EX rd!=0 && ((id_use_rs && id_rs==EX rd) || (id_use_rt && id_rt==EX rd)). pc_en=0, stage_en[0..1]=0, stage_en[2..]=1, ex_bubble=1 (EX valid<-0). State LDSTALL lasts exactly one cycle, then RUN.
- Forwarding (for EX instruction): youngest stage k in 3..STAGES-1 with valid, regwrite, rd==src, rd!=0 wins; else 0. Register 0 never forwarded. Regfile is write-first, so the final stage needs no bypass into ID.
- stall_cycles +1 each cycle in MEMWAIT or LDSTALL. Both counters saturate at 16'hFFFF.

## Timing
- Reset asserted: stage_valid=0, FSM=RUN, internal rd/flags=0, counters=0. Combinationally, stage_en=0, pc_en=0, pc_sel=0, ex_bubble=0, fwd_a=fwd_b=0 while Reset low.
- Reset mid-operation (including MEMWAIT) discards all state immediately; no pending ack is remembered.
- First clock after release: pc_en=1, stage_valid[0]<=1. A fetched instruction reaches stage k after k unstalled cycles.
- stage_en, pc_en, pc_sel, ex_bubble: combinational from inputs and state, zero latency. fwd_*: combinational from internal registers only.
- Branch and mem-wait in the same cycle: mem-wait wins. The branch must remain asserted until the pipeline advances.
- mem_ack without mem_req is ignored. An ack in the same cycle as the request gives zero wait.

## Configuration
- PIPE_CTRL_PERF_EN: defined -> stall_cycles/flush_count counters implemented as above. Undefined -> both ports tied to 16'h0000 and no counter flops.

## Test plan
- Reset release, no hazards, STAGES=5: stage_valid goes 00001 -> 00011 -> ... -> 11111 in 4 cycles; all stage_en=1 throughout.
- ALU producer r3 in EX, consumer reads r3 in ID: next cycle fwd_a=3. Producer one further (stage 4): fwd_a=4. Both producers present: youngest (3) is selected. Producer rd=0: fwd_a=0.
- Load r5 in EX, ID reads r5: one cycle with pc_en=0, ex_bubble=1, stall_cycles=1. The consumer then reaches EX with fwd_a=4.
- mem_req=1, mem_ack low for 3 cycles: stage_en=0 for 3 cycles with state frozen. The pipeline advances on the ack cycle; stall_cycles=3.
- ex_branch_taken=1 while a load-use hazard is present: pc_sel=1, no bubble, ID/EX valid cleared, flush_count=1. The same branch during MEMWAIT: no flush until ack.
- Reset low during MEMWAIT: all outputs 0 immediately, stage_valid=0; a normal restart follows release.
